// File: rtl/instr_mem_ctrl_pkg.sv
// Shared definitions for the instruction memory controller.
//   - default parameter values (data/address width, halt/fill word)
//   - opcode constants and an instruction encoder
//   - controller FSM state type
//   - the 6-word demo program held in words 0..5 at power-up
package instr_mem_ctrl_pkg;

    localparam int unsigned DEFAULT_DATA_W    = 16;
    localparam int unsigned DEFAULT_ADDR_W    = 8;
    localparam logic [15:0] DEFAULT_HALT_WORD = 16'hF000;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0100;
    localparam logic [3:0] OP_STORE = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PROG  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Instruction layout: opcode in the top nibble, three 4-bit operand fields.
    function automatic logic [15:0] mk_instr(input logic [3:0] op,
                                             input logic [3:0] f2,
                                             input logic [3:0] f1,
                                             input logic [3:0] f0);
        return {op, f2, f1, f0};
    endfunction

    localparam int unsigned DEMO_LEN = 6;

    localparam logic [15:0] DEMO_PROG [DEMO_LEN] = '{
        mk_instr(OP_LOAD,  4'h2, 4'h0, 4'h5),   // 16'h4205
        mk_instr(OP_LOAD,  4'h4, 4'h0, 4'hA),   // 16'h440A
        mk_instr(OP_ADD,   4'h6, 4'h5, 4'h0),   // 16'h0650
        mk_instr(OP_SUB,   4'hE, 4'h8, 4'h8),   // 16'h1E88
        mk_instr(OP_STORE, 4'h6, 4'h1, 4'h4),   // 16'h5614
        mk_instr(OP_HALT,  4'h0, 4'h0, 4'h0)    // 16'hF000
    };

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one write port, one synchronous read port.
// Ports:
//   clk, rst_n        clock, async active-low reset (read register only)
//   we, waddr, wdata  write port
//   re, raddr         read enable / address; rdata updates on the next edge
//   rdata             registered read data, held while re=0
// Power-up contents: HALT_WORD everywhere, demo program in words 0..5.
module imem_ram
    import instr_mem_ctrl_pkg::*;
#(
    parameter int unsigned       DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned       ADDR_W    = DEFAULT_ADDR_W,
    parameter int unsigned       DEPTH     = 256,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(DEFAULT_HALT_WORD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Tiny depths still allocate room for the demo program; the controller
    // never addresses words at or above DEPTH.
    localparam int unsigned ALLOC = (DEPTH < DEMO_LEN) ? DEMO_LEN : DEPTH;

    logic [DATA_W-1:0] mem [ALLOC] = '{
        0: DATA_W'(DEMO_PROG[0]),
        1: DATA_W'(DEMO_PROG[1]),
        2: DATA_W'(DEMO_PROG[2]),
        3: DATA_W'(DEMO_PROG[3]),
        4: DATA_W'(DEMO_PROG[4]),
        5: DATA_W'(DEMO_PROG[5]),
        default: HALT_WORD
    };

    // Array has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: fetch port with valid/ready handshake and
// 1-cycle latency, program-load mode, and a HALT_WORD fill sequence.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid, req_addr, req_ready  fetch request
//   rsp_valid, rsp_instr,
//   rsp_fault, rsp_ready            fetch response (fault = address >= DEPTH)
//   prog_en, prog_we,
//   prog_addr, prog_data            program-load mode and write port
//   prog_clr                        pulse to start filling memory with HALT_WORD
//   busy                            high whenever not in RUN
module instr_mem_ctrl
    import instr_mem_ctrl_pkg::*;
#(
    parameter int unsigned       DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned       ADDR_W    = DEFAULT_ADDR_W,
    parameter int unsigned       DEPTH     = 256,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(DEFAULT_HALT_WORD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_instr,
    output logic              rsp_fault,
    input  logic              rsp_ready,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_clr,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_last;
    logic              rsp_free;      // response slot free or being drained this cycle
    logic              accept;
    logic              req_fault;
    logic              prog_in_range;
    logic              valid_q, fault_q;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign clr_last      = (32'(clr_cnt) == DEPTH - 1);
    assign rsp_free      = !valid_q || rsp_ready;
    assign req_fault     = (32'(req_addr) >= DEPTH);
    assign prog_in_range = (32'(prog_addr) < DEPTH);
    assign accept        = req_valid && req_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: prog_clr wins over prog_en; entering PROG waits for any
    // pending response to drain, entering CLEAR does not.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (prog_clr) begin
                    state_d = CLEAR;
                end else if (prog_en && rsp_free) begin
                    state_d = PROG;
                end
            end
            PROG: begin
                if (prog_clr) begin
                    state_d = CLEAR;
                end else if (!prog_en) begin
                    state_d = RUN;
                end
            end
            CLEAR: begin
                if (clr_last) begin
                    state_d = prog_en ? PROG : RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs and write-port mux
    always_comb begin
        busy      = (state_q != RUN);
        req_ready = (state_q == RUN) && !prog_en && !prog_clr && rsp_free;
        ram_we    = 1'b0;
        ram_waddr = prog_addr;
        ram_wdata = prog_data;
        unique case (state_q)
            PROG: begin
                ram_we = prog_we && prog_in_range;
            end
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt;
                ram_wdata = HALT_WORD;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    // Fill counter: idles at zero, so each CLEAR entry starts from word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state_q == CLEAR && !clr_last) begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
        end else begin
            clr_cnt <= '0;
        end
    end

    // Response control; the RAM read register holds rsp_instr's data source
    // stable because it only loads on an accepted fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            fault_q <= req_fault;
        end else if (rsp_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_fault = fault_q;
    assign rsp_instr = fault_q ? HALT_WORD : ram_rdata;

    imem_ram #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .HALT_WORD (HALT_WORD)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (accept && !req_fault),
        .raddr (req_addr),
        .rdata (ram_rdata)
    );

endmodule

// File: doc/instr_mem_ctrl.md
INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 8, fetch/program address width.
REQ-003 SHALL have parameter DEPTH, default 256, number of words (1..2**ADDR_W).
REQ-004 SHALL have parameter HALT_WORD, default 16'hF000, fill/fault instruction.
REQ-005 SHALL have ports: clk in 1 (sole clock); rst_n in 1 (reset, asynchronous, active-low).
REQ-006 SHALL have ports: req_valid in 1 and req_addr in ADDR_W (fetch request); req_ready out 1.
REQ-007 SHALL have ports: rsp_valid out 1, rsp_instr out DATA_W, rsp_fault out 1 (response); rsp_ready in 1.
REQ-008 SHALL have ports: prog_en in 1 (load mode); prog_we in 1; prog_addr in ADDR_W; prog_data in DATA_W.
REQ-009 SHALL have ports: prog_clr in 1 (start fill pulse); busy out 1 (not in RUN).

Function
REQ-010 SHALL implement FSM states RUN, PROG, CLEAR; reset state RUN.
REQ-011 RUN->PROG when prog_en=1 and no response is pending or the pending response is consumed this cycle; PROG->RUN when prog_en=0.
REQ-012 RUN or PROG -> CLEAR on prog_clr=1, with prog_clr taking priority over prog_en; CLEAR->RUN (PROG if prog_en=1) after last word written.
REQ-013 CLEAR SHALL write HALT_WORD to addresses 0..DEPTH-1, one per cycle, via internal counter: DEPTH cycles total.
REQ-014 req_ready = (state==RUN) and prog_en=0 and prog_clr=0 and (rsp_valid=0 or rsp_ready=1).
REQ-015 A fetch is accepted on req_valid and req_ready; rsp_valid SHALL rise the next cycle with rsp_instr=MEM[req_addr] (1-cycle latency, back-to-back throughput 1/cycle).
REQ-016 rsp_valid, rsp_instr and rsp_fault SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-017 rsp_valid SHALL clear after a rsp_ready handshake when no new fetch is accepted in that cycle.
REQ-018 req_addr >= DEPTH SHALL return rsp_instr=HALT_WORD, rsp_fault=1; otherwise rsp_fault=0.
REQ-019 In PROG, prog_we=1 SHALL write prog_data to MEM[prog_addr] at that clock edge; prog_addr >= DEPTH is ignored.
REQ-020 prog_we outside PROG SHALL be ignored.
REQ-021 A response pending at PROG/CLEAR entry SHALL remain valid and deliverable; the RUN->PROG transition waits for it (REQ-011), but the CLEAR transition does not.
REQ-022 A fetch response SHALL reflect memory contents at the acceptance edge; no fetch and write occur in the same cycle.
REQ-023 busy SHALL equal (state != RUN).
REQ-024 At power-up (simulation initial), MEM SHALL hold HALT_WORD in every word, words 0..5 SHALL hold the default demo program, identical to the current 6-instruction LOAD/ADD/SUB/STORE/HALT sequence.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=RUN, rsp_valid=0, rsp_instr=0, rsp_fault=0, clear counter=0, busy=0.
REQ-026 Reset SHALL NOT modify MEM contents.
REQ-027 Reset mid-CLEAR SHALL abort the fill; words already written stay HALT_WORD, remaining words are unchanged.
REQ-028 Reset SHALL be released synchronously to clk (deassertion handled upstream); block assumes clean deassertion.

Structure
REQ-029 Shared package SHALL hold: FSM state enum, default DATA_W/ADDR_W, HALT_WORD, opcode constants (ADD 4'b0000, SUB 4'b0001, LOAD 4'b0100, STORE 4'b0101, HALT 4'b1111).
REQ-030 Storage SHALL be a sub-module imem_ram (1 write port, 1 synchronous read port, parametrised DATA_W/DEPTH); FSM, handshake and fill counter live in instr_mem_ctrl.
REQ-031 Write-port mux (PROG data vs CLEAR fill) SHALL be in instr_mem_ctrl.

Verification
REQ-032 Reset, fetch addr 0..5 with rsp_ready=1 -> 6 consecutive responses 16'h4205, 16'h440A, 16'h0650, 16'h1E88, 16'h5614, 16'hF000, rsp_fault=0.
REQ-033 Fetch addr 2, hold rsp_ready=0 for 4 cycles -> rsp_instr=16'h0650 stable, req_ready=0; release -> rsp_valid drops next cycle.
REQ-034 DEPTH=200, fetch addr 250 -> rsp_instr=16'hF000, rsp_fault=1.
REQ-035 prog_en=1, write 16'h1234 to addr 7, prog_en=0, fetch 7 -> 16'h1234; fetch attempted during PROG -> req_ready=0.
REQ-036 prog_clr pulse -> busy=1 for exactly 256 cycles, then fetch addr 0 -> 16'hF000.
REQ-037 rst_n=0 at cycle 100 of CLEAR -> busy=0 immediately; addr 99 reads 16'hF000, pre-loaded addr 150 keeps its value.
